// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready execute stage wrapping a 32-bit barrel shifter for SLL/SRL/SRA.
// Stage 1 registers the request; stage 2 holds the sign-fixed result under back-pressure.

module barrel_shifter (
  input  logic [31:0] i_operand,
  input  logic [31:0] i_shift,
  input  logic        i_left_not_right,
  output logic [31:0] o_result
);

  logic [31:0] w_pre;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_s3;
  logic [31:0] w_s4;
  logic [31:0] w_post;

  function automatic logic [31:0] bit_reverse(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int k = 0; k < 32; k++) begin
      r[k] = v[31-k];
    end
    return r;
  endfunction

  // Left shifts reuse the right-shift network by mirroring the operand in and out.
  assign w_pre  = i_left_not_right ? bit_reverse(i_operand) : i_operand;
  assign w_s0   = i_shift[0] ? {1'b0,  w_pre[31:1]}  : w_pre;
  assign w_s1   = i_shift[1] ? {2'b0,  w_s0[31:2]}   : w_s0;
  assign w_s2   = i_shift[2] ? {4'b0,  w_s1[31:4]}   : w_s1;
  assign w_s3   = i_shift[3] ? {8'b0,  w_s2[31:8]}   : w_s2;
  assign w_s4   = i_shift[4] ? {16'b0, w_s3[31:16]}  : w_s3;
  assign w_post = i_left_not_right ? bit_reverse(w_s4) : w_s4;

  assign o_result = (|i_shift[31:5]) ? 32'h0000_0000 : w_post;

endmodule

module shift_exec_stage #(
  parameter int TAG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_operand,
  input  logic [31:0]          in_shift,
  input  logic                 in_lnr,
  input  logic                 in_arith,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_zero,
  output logic [CNT_WIDTH-1:0] done_count
);

  logic                 r_s1_valid;
  logic [31:0]          r_s1_operand;
  logic [31:0]          r_s1_shift;
  logic                 r_s1_lnr;
  logic                 r_s1_arith;
  logic [TAG_WIDTH-1:0] r_s1_tag;

  logic                 r_s2_valid;
  logic [31:0]          r_s2_result;
  logic [TAG_WIDTH-1:0] r_s2_tag;
  logic                 r_s2_zero;
  logic [CNT_WIDTH-1:0] r_done_count;

  logic                 w_s2_free;
  logic                 w_s1_adv;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic [31:0]          w_shifted;
  logic [31:0]          w_fill_mask;
  logic [31:0]          w_fixed;

  barrel_shifter u_shifter (
    .i_operand        (r_s1_operand),
    .i_shift          (r_s1_shift),
    .i_left_not_right (r_s1_lnr),
    .o_result         (w_shifted)
  );

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  // Sign bits vacated by a right shift; a zero shift yields an empty mask.
  always_comb begin
    w_fill_mask = 32'h0000_0000;
    w_fixed     = w_shifted;
    if (|r_s1_shift[31:5]) begin
      w_fill_mask = 32'hFFFF_FFFF;
    end else begin
      w_fill_mask = ~(32'hFFFF_FFFF >> r_s1_shift[4:0]);
    end
    if (r_s1_arith && !r_s1_lnr && r_s1_operand[31]) begin
      w_fixed = w_shifted | w_fill_mask;
    end else begin
      w_fixed = w_shifted;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid   <= 1'b0;
      r_s1_operand <= 32'h0000_0000;
      r_s1_shift   <= 32'h0000_0000;
      r_s1_lnr     <= 1'b0;
      r_s1_arith   <= 1'b0;
      r_s1_tag     <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid   <= 1'b1;
      r_s1_operand <= in_operand;
      r_s1_shift   <= in_shift;
      r_s1_lnr     <= in_lnr;
      r_s1_arith   <= in_arith;
      r_s1_tag     <= in_tag;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= 32'h0000_0000;
      r_s2_tag    <= '0;
      r_s2_zero   <= 1'b1;
    end else if (w_s1_adv) begin
      r_s2_valid  <= 1'b1;
      r_s2_result <= w_fixed;
      r_s2_tag    <= r_s1_tag;
      r_s2_zero   <= (w_fixed == 32'h0000_0000);
    end else if (w_out_xfer) begin
      r_s2_valid  <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done_count <= '0;
    end else if (w_out_xfer) begin
      r_done_count <= r_done_count + CNT_WIDTH'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign out_zero   = r_s2_zero;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: directed boundary cases, back-pressure, reset,
// and randomized traffic against an arithmetic reference model (4-bit counter build).

module tb_shift_exec_stage;

  localparam int TW = 4;
  localparam int CW = 4;

  typedef struct {
    logic [31:0] result;
    logic [TW-1:0] tag;
    logic zero;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_operand = 32'h0;
  logic [31:0]   in_shift = 32'h0;
  logic          in_lnr = 1'b0;
  logic          in_arith = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_result;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic [CW-1:0] done_count;

  int   n_vec = 0;
  int   n_miss = 0;
  int   exp_cnt = 0;
  bit   rnd_bp = 1'b0;
  exp_t exp_q[$];

  shift_exec_stage #(.TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operand(in_operand), .in_shift(in_shift), .in_lnr(in_lnr),
    .in_arith(in_arith), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero),
    .done_count(done_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [31:0] sh,
                                            input logic lnr, input logic ar);
    if (lnr) return (sh >= 32) ? 32'h0 : (op << sh);
    if (ar)  return (sh >= 32) ? {32{op[31]}} : 32'($signed(op) >>> sh);
    return (sh >= 32) ? 32'h0 : (op >> sh);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [31:0] op, input logic [31:0] sh, input logic lnr,
                      input logic ar, input logic [TW-1:0] tag, input logic [31:0] res);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1; in_operand = op; in_shift = sh; in_lnr = lnr; in_arith = ar; in_tag = tag;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        e.result = res; e.tag = tag; e.zero = (res == 32'h0);
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  // Scoreboard monitor: every presented result must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("done_count", 32'(done_count), 32'(exp_cnt % (1 << CW)));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[0];
            chk("out_result", out_result, e.result);
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("out_zero", 32'(out_zero), 32'(e.zero));
            if (out_ready) void'(exp_q.pop_front());
          end
          if (out_ready) exp_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [31:0] op, sh;
    logic        lnr, ar;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;

    send(32'h0000_0001, 32'd31, 1'b1, 1'b0, 4'd5, 32'h8000_0000);
    @(negedge CLK);
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge CLK);
    chk("lat_valid", 32'(out_valid), 32'd1);
    @(posedge CLK); #1;
    send(32'h8000_0000, 32'd4,  1'b0, 1'b1, 4'd1, 32'hF800_0000);
    send(32'h8000_0000, 32'd40, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF);
    send(32'h8000_0000, 32'd40, 1'b0, 1'b0, 4'd3, 32'h0000_0000);
    send(32'h8000_0001, 32'd0,  1'b0, 1'b1, 4'd4, 32'h8000_0001);
    send(32'hF000_0000, 32'd36, 1'b1, 1'b1, 4'd6, 32'h0000_0000);
    send(32'h7FFF_FFFF, 32'd8,  1'b0, 1'b1, 4'd7, 32'h007F_FFFF);
    drain();

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge CLK); #1;
      send(32'(i + 1), 32'(i), 1'b1, 1'b0, 4'(i), 32'(i + 1) << i);
    end
    drain();
    repeat (2) @(posedge CLK);
    #1;
    chk("stream_count", 32'(done_count), 32'd8);

    out_ready = 1'b0;
    send(32'h1234_5678, 32'd4, 1'b0, 1'b0, 4'd9,  32'h0123_4567);
    send(32'h8765_4321, 32'd8, 1'b0, 1'b1, 4'd10, 32'hFF87_6543);
    in_valid = 1'b1; in_operand = 32'h0000_00FF; in_shift = 32'd4; in_lnr = 1'b1;
    in_arith = 1'b0; in_tag = 4'd11;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    send(32'h0000_00FF, 32'd4, 1'b1, 1'b0, 4'd11, 32'h0000_0FF0);
    drain();

    out_ready = 1'b0;
    send(32'hAAAA_AAAA, 32'd1, 1'b1, 1'b0, 4'd12, 32'h5555_5554);
    send(32'h5555_5555, 32'd1, 1'b0, 1'b0, 4'd13, 32'h2AAA_AAAA);
    do_reset();
    @(negedge CLK);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(done_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    send(32'h0000_0003, 32'd2, 1'b1, 1'b0, 4'd14, 32'h0000_000C);
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op  = $urandom;
      if ($urandom_range(0, 1) == 1) op[31] = 1'b1;
      sh  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 31));
      lnr = 1'($urandom_range(0, 1));
      ar  = 1'($urandom_range(0, 1));
      send(op, sh, lnr, ar, 4'($urandom), ref_shift(op, sh, lnr, ar));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
